// File: rtl/alu_response_checker.sv
// In-order scoreboard that checks ALU responses against results predicted at stimulus time.
// Build option: define CHECK_FLAGS_EN to include the zero/carry flags in the compare.
module alu_response_checker #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stim_valid,
    output logic        stim_ready,
    input  logic [2:0]  stim_op,
    input  logic [15:0] stim_a,
    input  logic [15:0] stim_b,
    input  logic        rsp_valid,
    input  logic [15:0] rsp_result,
    input  logic        rsp_zero,
    input  logic        rsp_carry,
    output logic        mismatch,
    output logic [15:0] fail_count,
    output logic [15:0] test_count,
    output logic        underflow_err,
    output logic        timeout_err,
    output logic        idle
);
    typedef enum logic [2:0] {
        OP_ADD    = 3'd0,
        OP_SUB    = 3'd1,
        OP_AND    = 3'd2,
        OP_OR     = 3'd3,
        OP_XOR    = 3'd4,
        OP_SLL    = 3'd5,
        OP_SRL    = 3'd6,
        OP_PASS_B = 3'd7
    } op_e;

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
`ifdef CHECK_FLAGS_EN
    localparam int unsigned EW = 18;
`else
    localparam int unsigned EW = 16;
`endif

    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_age;
    logic [15:0]   r_test_count;
    logic [15:0]   r_fail_count;
    logic          r_mismatch;
    logic          r_cmp_pend;
    logic          r_underflow;
    logic          r_timeout;

    logic [15:0]   w_exp_res;
    logic [EW-1:0] w_exp_entry;
    logic [EW-1:0] w_rsp_entry;
    logic [EW-1:0] w_head;
    logic          w_push;
    logic          w_pop;
    logic          w_timeout;
    logic          w_drop;
    logic          w_bad;

    always_comb begin
        w_exp_res = '0;
        case (op_e'(stim_op))
            OP_ADD:    w_exp_res = stim_a + stim_b;
            OP_SUB:    w_exp_res = stim_a - stim_b;
            OP_AND:    w_exp_res = stim_a & stim_b;
            OP_OR:     w_exp_res = stim_a | stim_b;
            OP_XOR:    w_exp_res = stim_a ^ stim_b;
            OP_SLL:    w_exp_res = stim_a << stim_b[3:0];
            OP_SRL:    w_exp_res = stim_a >> stim_b[3:0];
            OP_PASS_B: w_exp_res = stim_b;
            default:   w_exp_res = '0;
        endcase
    end

`ifdef CHECK_FLAGS_EN
    logic w_exp_carry;

    // Carry is the 17th sum bit for ADD and the borrow (a < b) for SUB.
    always_comb begin
        w_exp_carry = 1'b0;
        if (op_e'(stim_op) == OP_ADD)
            w_exp_carry = ({1'b0, stim_a} + {1'b0, stim_b}) > 17'h0FFFF;
        else if (op_e'(stim_op) == OP_SUB)
            w_exp_carry = stim_a < stim_b;
    end

    assign w_exp_entry = {w_exp_res, (w_exp_res == 16'h0000), w_exp_carry};
    assign w_rsp_entry = {rsp_result, rsp_zero, rsp_carry};
`else
    logic w_unused_flags;

    assign w_unused_flags = rsp_zero ^ rsp_carry;
    assign w_exp_entry    = w_exp_res;
    assign w_rsp_entry    = rsp_result;
`endif

    // Ready looks only at registered occupancy, so a pop never opens a slot in the same cycle.
    assign stim_ready = (r_count != CW'(DEPTH));
    assign w_head     = r_mem[r_rd_ptr];
    assign w_push     = stim_valid && stim_ready && !rst;
    assign w_pop      = rsp_valid && (r_count != '0);
    assign w_timeout  = !rsp_valid && (r_count != '0) && (r_age == AW'(TIMEOUT - 1));
    assign w_drop     = w_pop || w_timeout;
    assign w_bad      = (w_pop && (w_head != w_rsp_entry)) || w_timeout;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_exp_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_age        <= '0;
            r_test_count <= '0;
            r_fail_count <= '0;
            r_mismatch   <= 1'b0;
            r_cmp_pend   <= 1'b0;
            r_underflow  <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_mismatch <= w_bad;
            r_cmp_pend <= w_drop;

            if (rsp_valid && (r_count == '0))
                r_underflow <= 1'b1;
            if (w_timeout)
                r_timeout <= 1'b1;

            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_drop)
                r_rd_ptr <= r_rd_ptr + PW'(1);

            if (w_push && !w_drop)
                r_count <= r_count + CW'(1);
            else if (!w_push && w_drop)
                r_count <= r_count - CW'(1);

            // Age tracks how long the current head has waited; any removal restarts it.
            if (w_drop || (r_count == '0))
                r_age <= '0;
            else
                r_age <= r_age + AW'(1);

            if (w_drop && (r_test_count != 16'hFFFF))
                r_test_count <= r_test_count + 16'd1;
            if (w_bad && (r_fail_count != 16'hFFFF))
                r_fail_count <= r_fail_count + 16'd1;
        end
    end

    assign mismatch      = r_mismatch;
    assign test_count    = r_test_count;
    assign fail_count    = r_fail_count;
    assign underflow_err = r_underflow;
    assign timeout_err   = r_timeout;
    assign idle          = (r_count == '0) && !r_cmp_pend;

endmodule
